// File: rtl/dcache_tag_ctrl.sv
// Tag SRAM controller for the dcache: power-on invalidate sweep, 1-cycle lookup pipeline, write port.
// Optional macro DCACHE_TAG_BYPASS_EN forwards same-index write data to a colliding lookup.
module dcache_tag_ctrl #(
  parameter int unsigned DATA_WIDTH = 21,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  lkp_valid_i,
  output logic                  lkp_ready_o,
  input  logic [ADDR_WIDTH-1:0] lkp_index_i,
  input  logic [DATA_WIDTH-2:0] lkp_tag_i,
  output logic                  rsp_valid_o,
  output logic                  rsp_hit_o,
  output logic [DATA_WIDTH-1:0] rsp_entry_o,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [ADDR_WIDTH-1:0] wr_index_i,
  input  logic [DATA_WIDTH-1:0] wr_entry_i,
  output logic                  init_done_o,
  output logic                  csb0_o,
  output logic [ADDR_WIDTH-1:0] addr0_o,
  output logic [DATA_WIDTH-1:0] din0_o,
  output logic                  csb1_o,
  output logic [ADDR_WIDTH-1:0] addr1_o,
  input  logic [DATA_WIDTH-1:0] dout1_i
);

  localparam logic [0:0] StInit = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] sweep_q, sweep_d;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-2:0] tag_q;
  logic                  in_init, in_run, wr_fire, same_idx, lkp_fire, rd_en;
  logic [DATA_WIDTH-1:0] resp_entry;
`ifdef DCACHE_TAG_BYPASS_EN
  logic                  fwd_q;
  logic [DATA_WIDTH-1:0] fwd_entry_q;
`endif

  // Outputs are forced idle during the reset cycle even though state_q has not yet returned to INIT.
  always_comb begin
    in_init  = (state_q == StInit) && !rst_i;
    in_run   = (state_q == StRun) && !rst_i;
    wr_fire  = wr_valid_i && in_run;
    same_idx = wr_fire && (lkp_index_i == wr_index_i);
`ifdef DCACHE_TAG_BYPASS_EN
    lkp_ready_o = in_run;
    lkp_fire    = lkp_valid_i && lkp_ready_o;
    rd_en       = lkp_fire && !same_idx;
`else
    lkp_ready_o = in_run && !same_idx;
    lkp_fire    = lkp_valid_i && lkp_ready_o;
    rd_en       = lkp_fire;
`endif
    wr_ready_o  = in_run;
    init_done_o = in_run;
    csb0_o      = !(in_init || wr_fire);
    addr0_o     = in_init ? sweep_q : wr_index_i;
    din0_o      = in_init ? '0 : wr_entry_i;
    csb1_o      = !rd_en;
    addr1_o     = lkp_index_i;
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    if (state_q == StInit) begin
      sweep_d = sweep_q + 1'b1;
      if (sweep_q == '1) begin
        state_d = StRun;
      end
    end
  end

  always_comb begin
`ifdef DCACHE_TAG_BYPASS_EN
    resp_entry = fwd_q ? fwd_entry_q : dout1_i;
`else
    resp_entry = dout1_i;
`endif
    rsp_valid_o = rsp_valid_q && !rst_i;
    rsp_entry_o = rsp_valid_o ? resp_entry : '0;
    rsp_hit_o   = rsp_valid_o && resp_entry[DATA_WIDTH-1] &&
                  (resp_entry[DATA_WIDTH-2:0] == tag_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StInit;
      sweep_q     <= '0;
      rsp_valid_q <= 1'b0;
      tag_q       <= '0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      rsp_valid_q <= lkp_fire;
      if (lkp_fire) begin
        tag_q <= lkp_tag_i;
      end
    end
  end

`ifdef DCACHE_TAG_BYPASS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fwd_q       <= 1'b0;
      fwd_entry_q <= '0;
    end else begin
      fwd_q <= lkp_fire && same_idx;
      if (lkp_fire && same_idx) begin
        fwd_entry_q <= wr_entry_i;
      end
    end
  end
`endif

endmodule
